// File: rtl/expansao_chave_pkg.sv
// Shared AES-128 key-expansion definitions: round count, FSM encodings, Rcon table.
// Also intended for reuse by the cipher round controller.
package expansao_chave_pkg;

    localparam int unsigned KEY_W              = 128;
    localparam int unsigned WORD_W             = 32;
    localparam int unsigned RODADA_W           = 4;
    localparam int unsigned NUM_RODADAS_AES128 = 10;

    localparam logic [0:0] OCIOSO = 1'b0;
    localparam logic [0:0] EMITE  = 1'b1;

    // Round constant in the most significant byte; index 1..10, zero elsewhere.
    function automatic logic [WORD_W-1:0] rcon(input logic [RODADA_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h000000};
    endfunction

endpackage

// File: rtl/substituiBytes.sv
// AES SubBytes over a 128-bit block: the forward S-box applied to each of 16 bytes.
module substituiBytes
    import expansao_chave_pkg::*;
(
    input  logic [KEY_W-1:0] dado_i,
    output logic [KEY_W-1:0] dado_o
);

    // Byte 0x00 lives in the top 8 bits of the table.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    for (genvar g = 0; g < 16; g++) begin : g_byte
        assign dado_o[8*g +: 8] = sbox(dado_i[8*g +: 8]);
    end

endmodule

// File: rtl/expansao_chave.sv
// AES-128 key expansion: emits round keys 0..NUM_RODADAS one per accepted handshake,
// computing each next key on the fly from the current one.
module expansao_chave
    import expansao_chave_pkg::*;
#(
    parameter int unsigned NUM_RODADAS = NUM_RODADAS_AES128
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inicio,
    input  logic [KEY_W-1:0]    chave,
    input  logic                aceito,
    output logic [KEY_W-1:0]    chave_rodada,
    output logic [RODADA_W-1:0] rodada,
    output logic                valido,
    output logic                ocupado,
    output logic                fim
);

    logic [0:0]          estado_q, estado_d;
    logic [KEY_W-1:0]    chave_q, chave_d;
    logic [RODADA_W-1:0] rodada_q, rodada_d;
    logic                fim_q, fim_d;

    logic [WORD_W-1:0] w0, w1, w2, w3, rot_w3, temp;
    logic [WORD_W-1:0] n0, n1, n2, n3;
    logic [KEY_W-1:0]  sub_out;
    logic [KEY_W-1:0]  prox_chave;
    logic              unused_sub;

    // Next round key derived from the key currently on the output.
    assign {w0, w1, w2, w3} = chave_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    substituiBytes u_sub (
        .dado_i ({96'h0, rot_w3}),
        .dado_o (sub_out)
    );

    assign unused_sub = ^sub_out[KEY_W-1:WORD_W];
    assign temp       = sub_out[WORD_W-1:0] ^ rcon(RODADA_W'(rodada_q + 4'd1));
    assign n0         = w0 ^ temp;
    assign n1         = w1 ^ n0;
    assign n2         = w2 ^ n1;
    assign n3         = w3 ^ n2;
    assign prox_chave = {n0, n1, n2, n3};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            chave_q  <= '0;
            rodada_q <= '0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            chave_q  <= chave_d;
            rodada_q <= rodada_d;
            fim_q    <= fim_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        chave_d  = chave_q;
        rodada_d = rodada_q;
        fim_d    = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    chave_d  = chave;
                    rodada_d = '0;
                    estado_d = EMITE;
                end
            end
            EMITE: begin
                if (aceito) begin
                    if (rodada_q == RODADA_W'(NUM_RODADAS)) begin
                        chave_d  = '0;
                        rodada_d = '0;
                        fim_d    = 1'b1;
                        estado_d = OCIOSO;
                    end else begin
                        chave_d  = prox_chave;
                        rodada_d = RODADA_W'(rodada_q + 4'd1);
                    end
                end
            end
            default: begin
                chave_d  = '0;
                rodada_d = '0;
                estado_d = OCIOSO;
            end
        endcase
    end

    assign chave_rodada = chave_q;
    assign rodada       = rodada_q;
    assign valido       = (estado_q == EMITE);
    assign ocupado      = (estado_q != OCIOSO);
    assign fim          = fim_q;

endmodule

// File: tb/tb_expansao_chave.sv
// Directed bench for expansao_chave: FIPS-197 round keys, handshake stalls,
// ignored restarts, asynchronous reset and back-to-back sequences.
module tb_expansao_chave;

    logic         clock;
    logic         reset;
    logic         inicio;
    logic         aceito;
    logic [127:0] chave;
    logic [127:0] chave_rodada;
    logic [3:0]   rodada;
    logic         valido;
    logic         ocupado;
    logic         fim;

    expansao_chave #(.NUM_RODADAS(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .inicio       (inicio),
        .chave        (chave),
        .aceito       (aceito),
        .chave_rodada (chave_rodada),
        .rodada       (rodada),
        .valido       (valido),
        .ocupado      (ocupado),
        .fim          (fim)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         inicio;
        logic         aceito;
        logic [127:0] chave;
        logic         exp_valido;
        logic [3:0]   exp_rodada;
        logic [127:0] exp_chave;
        logic         exp_fim;
        logic         exp_ocupado;
    } vec_t;

    vec_t         vecs[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] rk [0:10];
    logic [127:0] key_fips;
    logic [127:0] key_outra;
    logic [127:0] key_zero_f;
    logic [127:0] rk10_zero_f;
    logic         pat [4];

    function automatic vec_t mk(input logic ini, input logic acc, input logic [127:0] k,
                                input logic ev, input logic [3:0] er, input logic [127:0] ek,
                                input logic ef, input logic eo);
        vec_t v;
        v.inicio = ini;  v.aceito = acc;  v.chave = k;
        v.exp_valido = ev;  v.exp_rodada = er;  v.exp_chave = ek;
        v.exp_fim = ef;  v.exp_ocupado = eo;
        return v;
    endfunction

    task automatic check(input string nome, input logic ev, input logic [3:0] er,
                         input logic [127:0] ek, input logic ef, input logic eo);
        n_vec++;
        if (valido !== ev || rodada !== er || chave_rodada !== ek || fim !== ef || ocupado !== eo) begin
            n_err++;
            $display("FAIL %s: got valido=%b rodada=%0d chave=%h fim=%b ocupado=%b; want valido=%b rodada=%0d chave=%h fim=%b ocupado=%b",
                     nome, valido, rodada, chave_rodada, fim, ocupado, ev, er, ek, ef, eo);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int idx;
        int j;

        key_fips    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_outra   = 128'hffeeddccbbaa99887766554433221100;
        key_zero_f  = 128'h000102030405060708090a0b0c0d0e0f;
        rk10_zero_f = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        rk[0]  = key_fips;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        reset  = 1'b1;
        inicio = 1'b0;
        aceito = 1'b0;
        chave  = '0;
        #3;
        check("reset_state", 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);
        #9;
        reset = 1'b0;

        // Continuous accept: eleven consecutive keys, then the fim pulse.
        vecs.push_back(mk(1'b1, 1'b1, key_fips, 1'b1, 4'd0, rk[0], 1'b0, 1'b1));
        for (int k = 1; k <= 10; k++)
            vecs.push_back(mk(1'b0, 1'b1, key_fips, 1'b1, 4'(k), rk[k], 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, key_fips, 1'b0, 4'd0, 128'h0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, key_fips, 1'b0, 4'd0, 128'h0, 1'b0, 1'b0));

        // Stalling accept pattern 1,0,0,1 with chave changing after the start.
        vecs.push_back(mk(1'b1, 1'b0, key_fips, 1'b1, 4'd0, rk[0], 1'b0, 1'b1));
        idx = 0;
        j   = 0;
        while (j < 100) begin
            if (pat[j % 4]) begin
                if (idx == 10) begin
                    vecs.push_back(mk(1'b0, 1'b1, key_outra, 1'b0, 4'd0, 128'h0, 1'b1, 1'b0));
                    break;
                end
                idx++;
                vecs.push_back(mk(1'b0, 1'b1, key_outra, 1'b1, 4'(idx), rk[idx], 1'b0, 1'b1));
            end else begin
                vecs.push_back(mk(1'b0, 1'b0, key_outra, 1'b1, 4'(idx), rk[idx], 1'b0, 1'b1));
            end
            j++;
        end
        vecs.push_back(mk(1'b0, 1'b0, key_outra, 1'b0, 4'd0, 128'h0, 1'b0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            inicio = vecs[i].inicio;
            aceito = vecs[i].aceito;
            chave  = vecs[i].chave;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_valido, vecs[i].exp_rodada,
                  vecs[i].exp_chave, vecs[i].exp_fim, vecs[i].exp_ocupado);
        end

        // Restart request at rodada 4 with another key is ignored.
        inicio = 1'b1; aceito = 1'b1; chave = key_fips;
        step();
        check("pre_start", 1'b1, 4'd0, rk[0], 1'b0, 1'b1);
        chave = key_outra;
        for (int k = 1; k <= 10; k++) begin
            inicio = (k == 5);
            step();
            check($sformatf("pre_rk%0d", k), 1'b1, 4'(k), rk[k], 1'b0, 1'b1);
        end
        inicio = 1'b0;
        step();
        check("pre_fim", 1'b0, 4'd0, 128'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-sequence, then a fresh key.
        inicio = 1'b1; chave = key_fips;
        step();
        inicio = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        check("rst_rk6", 1'b1, 4'd6, rk[6], 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_async", 1'b0, 4'd0, 128'h0, 1'b0, 1'b0);
        reset  = 1'b0;
        inicio = 1'b1;
        chave  = key_zero_f;
        step();
        check("rst_rk0", 1'b1, 4'd0, key_zero_f, 1'b0, 1'b1);
        inicio = 1'b0;
        for (int k = 1; k <= 10; k++) step();
        check("rst_rk10", 1'b1, 4'd10, rk10_zero_f, 1'b0, 1'b1);
        step();
        check("rst_fim", 1'b0, 4'd0, 128'h0, 1'b1, 1'b0);

        // inicio held high: fim coincides with the restart edge.
        inicio = 1'b1; chave = key_fips;
        for (int s = 0; s < 2; s++) begin
            step();
            check($sformatf("b2b%0d_rk0", s), 1'b1, 4'd0, rk[0], 1'b0, 1'b1);
            for (int k = 1; k <= 10; k++) step();
            check($sformatf("b2b%0d_rk10", s), 1'b1, 4'd10, rk[10], 1'b0, 1'b1);
            step();
            check($sformatf("b2b%0d_fim", s), 1'b0, 4'd0, 128'h0, 1'b1, 1'b0);
        end
        step();
        check("b2b_restart", 1'b1, 4'd0, rk[0], 1'b0, 1'b1);
        inicio = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
